// File: rtl/sine_phase_gen.sv
// Phase-accumulator ROM address generator with boundary-synchronised retune and stop.
// Optional quarter-wave addressing: define SINE_QUARTER_WAVE_EN.
module sine_phase_gen #(
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ACC_WIDTH-1:0]  ftw,
  input  logic                  ftw_valid,
  output logic                  ftw_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  en,
  output logic                  wrap,
  output logic                  busy,
  output logic                  negate
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_WIDTH-1:0]  phase;
  logic [ACC_WIDTH-1:0]  ftw_act;
  logic [ACC_WIDTH-1:0]  ftw_shd;
  logic                  pending;

  logic                  sample;
  logic [ACC_WIDTH:0]    sum;
  logic                  carry;
  logic                  xfer;
  logic                  apply;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  neg_nxt;

  always_comb begin
    sample    = tick && (state != S_IDLE);
    sum       = {1'b0, phase} + {1'b0, ftw_act};
    carry     = sum[ACC_WIDTH];
    xfer      = ftw_valid && !pending;
    // Shadow word lands immediately when idle, otherwise only on a wrap sample.
    apply     = pending && ((state == S_IDLE) || (sample && carry));
    ftw_ready = !pending;
  end

`ifdef SINE_QUARTER_WAVE_EN
  logic [1:0]            quad;
  logic [ADDR_WIDTH-1:0] qaddr;

  always_comb begin
    quad     = phase[ACC_WIDTH-1 -: 2];
    qaddr    = phase[ACC_WIDTH-3 -: ADDR_WIDTH];
    addr_nxt = quad[0] ? ~qaddr : qaddr;
    neg_nxt  = quad[1];
  end
`else
  always_comb begin
    addr_nxt = phase[ACC_WIDTH-1 -: ADDR_WIDTH];
    neg_nxt  = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A zero word never wraps, and a stop coinciding with the wrap sample
        // already ends the period, so both skip STOPPING.
        if (stop) begin
          if ((ftw_act == '0) || (sample && carry)) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_STOPPING;
          end
        end
      end
      S_STOPPING: begin
        if (sample && carry) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      ftw_act <= '0;
      ftw_shd <= '0;
      pending <= 1'b0;
      address <= '0;
      en      <= 1'b0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
      negate  <= 1'b0;
    end else begin
      busy <= (state != S_IDLE);
      en   <= sample;
      wrap <= sample && carry;

      if ((state == S_IDLE) && start) begin
        phase <= '0;
      end else if (sample) begin
        phase <= sum[ACC_WIDTH-1:0];
      end

      if (sample) begin
        address <= addr_nxt;
        negate  <= neg_nxt;
      end

      // xfer needs pending low and apply needs it high, so they never collide.
      if (xfer) begin
        ftw_shd <= ftw;
        pending <= 1'b1;
      end else if (apply) begin
        ftw_act <= ftw_shd;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed self-checking bench for sine_phase_gen; quarter-wave vectors when
// SINE_QUARTER_WAVE_EN is defined, full-period vectors otherwise.
module tb_sine_phase_gen;

  localparam int unsigned ACC_WIDTH  = 16;
  localparam int unsigned ADDR_WIDTH = 6;

  logic                  clk;
  logic                  rst;
  logic                  tick;
  logic                  start;
  logic                  stop;
  logic [ACC_WIDTH-1:0]  ftw;
  logic                  ftw_valid;
  logic                  ftw_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic                  en;
  logic                  wrap;
  logic                  busy;
  logic                  negate;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  sine_phase_gen #(
    .ACC_WIDTH (ACC_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .ftw      (ftw),
    .ftw_valid(ftw_valid),
    .ftw_ready(ftw_ready),
    .address  (address),
    .en       (en),
    .wrap     (wrap),
    .busy     (busy),
    .negate   (negate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse(input int unsigned exp_addr, input logic exp_wrap, input logic exp_neg);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("en", en, 1);
    check_eq("address", address, exp_addr);
    check_eq("wrap", wrap, exp_wrap);
    check_eq("negate", negate, exp_neg);
  endtask

  task automatic do_sample(input int unsigned exp_addr, input logic exp_wrap, input logic exp_neg);
    tick_pulse(exp_addr, exp_wrap, exp_neg);
    step();
    check_eq("en_one_cycle", en, 0);
    check_eq("wrap_one_cycle", wrap, 0);
    check_eq("addr_hold", address, exp_addr);
    step();
    step();
  endtask

  task automatic load_ftw(input logic [ACC_WIDTH-1:0] w);
    ftw       = w;
    ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    check_eq("ready_after_xfer", ftw_ready, 0);
    step();
    check_eq("ready_idle_apply", ftw_ready, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("busy_after_start", busy, 1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    ftw = '0; ftw_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_address", address, 0);
    check_eq("rst_en", en, 0);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_negate", negate, 0);
    check_eq("rst_ready", ftw_ready, 1);

`ifdef SINE_QUARTER_WAVE_EN
    // 256 samples per period, four 64-sample quadrants.
    load_ftw(16'd256);
    do_start();
    for (int k = 0; k < 256; k++) begin
      int unsigned quad;
      int unsigned idx;
      quad = k / 64;
      idx  = k % 64;
      do_sample((quad % 2 == 1) ? 63 - idx : idx, k == 255, quad >= 2);
    end
    do_sample(0, 1'b0, 1'b0);
`else
    // Full-period sweep at 1024: addresses step by one, wrap on 63.
    load_ftw(16'd1024);
    do_start();
    for (int a = 0; a < 64; a++) do_sample(a, a == 63, 1'b0);
    do_sample(0, 1'b0, 1'b0);

    // Retune to 2048 mid-period; a second offer (1024) stalls until the wrap.
    for (int a = 1; a < 10; a++) do_sample(a, 1'b0, 1'b0);
    ftw       = 16'd2048;
    ftw_valid = 1'b1;
    step();
    ftw = 16'd1024;
    check_eq("ready_pending", ftw_ready, 0);
    for (int a = 10; a < 63; a++) do_sample(a, 1'b0, 1'b0);
    check_eq("ready_stall", ftw_ready, 0);
    tick_pulse(63, 1'b1, 1'b0);
    check_eq("ready_at_wrap", ftw_ready, 1);
    step();
    check_eq("second_xfer", ftw_ready, 0);
    ftw_valid = 1'b0;
    step();
    step();
    for (int k = 0; k < 32; k++) do_sample(2 * k, k == 31, 1'b0);
    check_eq("ready_after_retune", ftw_ready, 1);

    // Graceful stop at address 20: period completes, then idle.
    for (int a = 0; a < 20; a++) do_sample(a, 1'b0, 1'b0);
    do_stop();
    check_eq("busy_stopping", busy, 1);
    step();
    check_eq("busy_stopping2", busy, 1);
    for (int a = 20; a < 64; a++) do_sample(a, a == 63, 1'b0);
    check_eq("busy_after_stop", busy, 0);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check_eq("en_idle_tick", en, 0);
      step();
      step();
    end

    // Zero tuning word: address sticks at 0, stop returns straight to idle.
    load_ftw(16'd0);
    do_start();
    for (int i = 0; i < 3; i++) do_sample(0, 1'b0, 1'b0);
    do_stop();
    step();
    check_eq("busy_zero_stop", busy, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("en_zero_idle", en, 0);
    step();

    // Reset at address 37 with a pending word and a coincident tick.
    load_ftw(16'd1024);
    do_start();
    for (int a = 0; a < 38; a++) do_sample(a, 1'b0, 1'b0);
    ftw       = 16'd2048;
    ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    check_eq("ready_before_rst", ftw_ready, 0);
    rst  = 1'b1;
    tick = 1'b1;
    step();
    rst  = 1'b0;
    tick = 1'b0;
    check_eq("mid_rst_address", address, 0);
    check_eq("mid_rst_en", en, 0);
    check_eq("mid_rst_wrap", wrap, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_negate", negate, 0);
    check_eq("mid_rst_ready", ftw_ready, 1);
    step();
    step();
    // Active and pending words both cleared: start yields a frozen address.
    do_start();
    do_sample(0, 1'b0, 1'b0);
    do_sample(0, 1'b0, 1'b0);
    do_stop();
    step();
    load_ftw(16'd1024);
    do_start();
    for (int a = 0; a < 4; a++) do_sample(a, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sine_phase_gen.md
# sine_phase_gen

Phase-accumulator address generator that drives the sine-table ROM: it turns a periodic `tick` strobe into a stream of ROM addresses with a matching read-enable. The output frequency is set by a programmable tuning word. It sits between `TickCounter` (upstream) and `ROM` (downstream), replacing the free-running address counter. Tuning-word changes and stop requests take effect only at a period boundary, so the waveform never has a discontinuity.

## Interface
- `ACC_WIDTH`, 16: phase accumulator width in bits.
- `ADDR_WIDTH`, 6: ROM address width in bits; must be less than or equal to `ACC_WIDTH` minus 2.
- `clk`  in  1: system clock (100 MHz). Only clock of the block.
- `rst`  in  1: synchronous, active-high reset.
- `tick`  in  1: one-cycle sample strobe from `TickCounter`.
- `start`  in  1: level or pulse; sampled only in IDLE.
- `stop`  in  1: level or pulse; sampled only in RUN.
- `ftw`  in  ACC_WIDTH: frequency tuning word.
- `ftw_valid`  in  1: `ftw` offered.
- `ftw_ready`  out  1: shadow register free; a transfer happens when `ftw_valid` and `ftw_ready` are both high.
- `address`  out  ADDR_WIDTH: ROM address; connects to ROM `address`.
- `en`  out  1: one-cycle read enable; connects to ROM `en`.
- `wrap`  out  1: one-cycle pulse marking the last sample of a period.
- `busy`  out  1: high in RUN and STOPPING.
- `negate`  out  1: sign flag for the downstream stage (see Configuration).

## Operation
- Registers:
  - `phase` (ACC_WIDTH bits)
  - `ftw_act` (active tuning word)
  - `ftw_shd` (shadow tuning word) plus a `pending` flag
- State machine with states IDLE, RUN and STOPPING.
  - IDLE: when `start` is high, clear `phase` to 0 and go to RUN. `tick` is ignored in IDLE. When `start` and `stop` are high together, the block goes to RUN.
  - RUN: when `stop` is high, go to STOPPING. `start` is ignored.
  - STOPPING: on a sample with `wrap`=1, go to IDLE. If `ftw_act`==0 when `stop` is seen, go directly to IDLE.
- Per sample, i.e. on `tick` in RUN or STOPPING:
  - `address` ← `phase[ACC_WIDTH-1 -: ADDR_WIDTH]`, taken from the value before the add.
  - `phase` ← `phase` + `ftw_act`, modulo 2^ACC_WIDTH.
  - `wrap` ← carry-out of that add.
  - `en` ← 1.
  - The sample carrying `wrap` is still emitted.
- Tuning-word handshake:
  - `ftw_ready` = !`pending`. A transfer loads `ftw_shd` and sets `pending`.
  - In IDLE, the pending word moves to `ftw_act` on the next cycle.
  - In RUN or STOPPING, the pending word moves to `ftw_act` only in the cycle that produces a sample with `wrap`=1; that add uses the old word. `pending` clears in that same cycle.
  - A transfer that occurs in the same cycle as a wrap sample is not applied until the following wrap.
- `address` holds its value between samples.
- `ftw_act`==0 is legal: the same address repeats and `wrap` never asserts.

## Timing
- Reset values:
  - `address`=0, `en`=0, `wrap`=0, `busy`=0, `negate`=0, `ftw_ready`=1
  - `phase`=0, `ftw_act`=0, `pending`=0, state IDLE
- Latency: `tick` in cycle n produces `en`, `address`, `wrap` and `negate` in cycle n+1. All outputs are registered.
- `en` and `wrap` are high for exactly one cycle per tick.
- `busy` changes in the cycle after the state transition that causes it.
- `rst` asserted mid-operation: all registers take their reset values in the next cycle and any pending word is discarded. No `en` is produced in the cycle after reset.
- Ticks arrive at least 2 cycles apart; back-to-back ticks are unsupported.

## Configuration
- `SINE_QUARTER_WAVE_EN` defined:
  - `q` = `phase[ACC_WIDTH-1:ACC_WIDTH-2]`.
  - `a` = `phase[ACC_WIDTH-3 -: ADDR_WIDTH]`.
  - `address` = `q[0]` ? ~`a` : `a`.
  - `negate` = `q[1]`, registered alongside `address`.
  - The ROM holds a quarter period.
- Not defined:
  - `address` uses the top ADDR_WIDTH bits of `phase`.
  - `negate` is tied to 0.
  - The ROM holds a full period.

## Test plan
- Full-period sweep: ftw=1024, start, tick every 4 cycles. Expect addresses 0,1,…,63, then 0. `wrap`=1 only on the sample with address 63. Each `en` lags its `tick` by 1 cycle.
- Boundary-aligned retune: running at ftw=1024, offer ftw=2048 at sample 10. Expect `ftw_ready` low until the wrap, the remaining addresses stepping by 1 to 63, then 0,2,4,… after the wrap. A second offer before the wrap stalls on `ftw_ready`=0.
- Graceful stop: assert `stop` at address 20. Expect samples to continue through 63 with `wrap`, then `busy`=0 and no further `en` despite ticks.
- Zero tuning word: ftw=0, start, then stop. Expect address to repeat 0 with no `wrap`, and an immediate return to IDLE on `stop`.
- Reset mid-run: assert `rst` at address 37. Expect all outputs at reset values the next cycle; after start with ftw=1024, addresses resume from 0.
- With `SINE_QUARTER_WAVE_EN`, ACC_WIDTH=16, ftw=256: expect addresses 0→63, 63→0, 0→63, 63→0, with `negate`=1 for the last two quadrants.
